// File: rtl/tcp_header_tx.sv
// TCP header serialiser: latches fields on start, sums pseudo-header + header + payload sum, streams big-endian beats.
// Latency 17 cycles start-to-first-beat (19 with the MSS option); m_data/m_last hold while m_valid && !m_ready.
// Optional MSS option (02 04 mss) on SYN segments when TCP_MSS_OPT_EN is defined.
module tcp_header_tx #(
    parameter int          DATA_BYTES = 1,
    parameter logic [15:0] URG_PTR    = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic [31:0]             ip_sa,
    input  logic [31:0]             ip_da,
    input  logic [15:0]             payload_len,
    input  logic [15:0]             payload_sum,
    input  logic [15:0]             src_port,
    input  logic [15:0]             dst_port,
    input  logic [31:0]             seq_num,
    input  logic [31:0]             ack_num,
    input  logic [7:0]              flags,
    input  logic [15:0]             window,
    input  logic [15:0]             mss,
    output logic [8*DATA_BYTES-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    generate
        if (DATA_BYTES != 1 && DATA_BYTES != 2 && DATA_BYTES != 4) begin : g_bad_width
            $error("tcp_header_tx: DATA_BYTES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SUM, EMIT} state_t;

    localparam logic [4:0] DB5 = 5'(DATA_BYTES);

    state_t      state, state_nxt;
    logic [31:0] sa_q, da_q, seq_q, ack_q;
    logic [15:0] plen_q, psum_q, sp_q, dp_q, win_q, mss_q;
    logic [7:0]  flags_q;
    logic [4:0]  word_idx, byte_ptr;
    logic [15:0] csum;
    logic        opt;

    logic [4:0]  hdr_len, n_words;
    logic [3:0]  doff;
    logic [15:0] tcp_len, word;
    logic [16:0] sum_w;
    logic        last_beat;
    logic [7:0]  hdr_b [24];

    assign busy      = (state != IDLE);
    assign hdr_len   = opt ? 5'd24 : 5'd20;
    assign doff      = opt ? 4'd6 : 4'd5;
    assign n_words   = opt ? 5'd18 : 5'd16;
    assign tcp_len   = {11'b0, hdr_len} + plen_q;
    assign last_beat = (byte_ptr + DB5 == hdr_len);
    assign m_valid   = (state == EMIT);
    assign m_last    = (state == EMIT) && last_beat;

    // Folding the carry every cycle keeps the stored sum below 0x10000, so one fold always suffices.
    assign sum_w = {1'b0, csum} + {1'b0, word};

    always_comb begin
        word = 16'h0000;
        case (word_idx)
            5'd0:  word = sa_q[31:16];
            5'd1:  word = sa_q[15:0];
            5'd2:  word = da_q[31:16];
            5'd3:  word = da_q[15:0];
            5'd4:  word = 16'h0006;
            5'd5:  word = tcp_len;
            5'd6:  word = sp_q;
            5'd7:  word = dp_q;
            5'd8:  word = seq_q[31:16];
            5'd9:  word = seq_q[15:0];
            5'd10: word = ack_q[31:16];
            5'd11: word = ack_q[15:0];
            5'd12: word = {doff, 4'b0, flags_q};
            5'd13: word = win_q;
            5'd14: word = URG_PTR;
            5'd15: word = psum_q;
            5'd16: word = 16'h0204;
            5'd17: word = mss_q;
            default: word = 16'h0000;
        endcase
    end

    always_comb begin
        hdr_b[0]  = sp_q[15:8];   hdr_b[1]  = sp_q[7:0];
        hdr_b[2]  = dp_q[15:8];   hdr_b[3]  = dp_q[7:0];
        hdr_b[4]  = seq_q[31:24]; hdr_b[5]  = seq_q[23:16];
        hdr_b[6]  = seq_q[15:8];  hdr_b[7]  = seq_q[7:0];
        hdr_b[8]  = ack_q[31:24]; hdr_b[9]  = ack_q[23:16];
        hdr_b[10] = ack_q[15:8];  hdr_b[11] = ack_q[7:0];
        hdr_b[12] = {doff, 4'b0}; hdr_b[13] = flags_q;
        hdr_b[14] = win_q[15:8];  hdr_b[15] = win_q[7:0];
        hdr_b[16] = ~csum[15:8];  hdr_b[17] = ~csum[7:0];
        hdr_b[18] = URG_PTR[15:8]; hdr_b[19] = URG_PTR[7:0];
        hdr_b[20] = 8'h02;        hdr_b[21] = 8'h04;
        hdr_b[22] = mss_q[15:8];  hdr_b[23] = mss_q[7:0];
    end

    always_comb begin
        m_data = '0;
        if (state == EMIT) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                m_data[8*(DATA_BYTES-1-i) +: 8] = hdr_b[byte_ptr + 5'(i)];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SUM;
            SUM:  if (word_idx == n_words - 5'd1) state_nxt = EMIT;
            EMIT: if (m_ready && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            csum     <= 16'h0000;
            word_idx <= 5'd0;
            byte_ptr <= 5'd0;
            sa_q     <= '0; da_q  <= '0; seq_q <= '0; ack_q   <= '0;
            plen_q   <= '0; psum_q <= '0; sp_q <= '0; dp_q    <= '0;
            win_q    <= '0; mss_q <= '0; flags_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    sa_q    <= ip_sa;       da_q   <= ip_da;
                    seq_q   <= seq_num;     ack_q  <= ack_num;
                    plen_q  <= payload_len; psum_q <= payload_sum;
                    sp_q    <= src_port;    dp_q   <= dst_port;
                    win_q   <= window;      mss_q  <= mss;
                    flags_q <= flags;
                    csum     <= 16'h0000;
                    word_idx <= 5'd0;
                    byte_ptr <= 5'd0;
                end
                SUM: begin
                    csum     <= sum_w[15:0] + {15'b0, sum_w[16]};
                    word_idx <= word_idx + 5'd1;
                end
                EMIT: if (m_ready) byte_ptr <= byte_ptr + DB5;
                default: ;
            endcase
        end
    end

`ifdef TCP_MSS_OPT_EN
    logic opt_q;
    always_ff @(posedge clk) begin
        if (rst)                        opt_q <= 1'b0;
        else if (state == IDLE && start) opt_q <= flags[1];
    end
    assign opt = opt_q;
`else
    assign opt = 1'b0;
`endif

endmodule

// File: tb/tb_tcp_header_tx.sv
// Randomised bench for tcp_header_tx: byte-lane 1 and 4 instances checked against a byte-list checksum model.
module tb_tcp_header_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0, rdy1 = 1'b1, rdy4 = 1'b1;
    logic [31:0] sa = 0, da = 0, seq = 0, ack = 0;
    logic [15:0] plen = 0, psum = 0, sp = 0, dp = 0, win = 0, mss = 0;
    logic [7:0]  flg = 0;
    logic        busy1, valid1, last1, busy4, valid4, last4;
    logic [7:0]  data1;
    logic [31:0] data4;

    logic [31:0] m_sa, m_da, m_seq, m_ack;
    logic [15:0] m_plen, m_psum, m_sp, m_dp, m_win, m_mss;
    logic [7:0]  m_flg;

    int checks = 0, errors = 0;
    logic [7:0] exp_q[$], got_q[$];
    int lat, beats, stall_bad;
    bit timed_out;

    always #5 clk = ~clk;

    tcp_header_tx #(.DATA_BYTES(1), .URG_PTR(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1),
        .ip_sa(sa), .ip_da(da), .payload_len(plen), .payload_sum(psum),
        .src_port(sp), .dst_port(dp), .seq_num(seq), .ack_num(ack),
        .flags(flg), .window(win), .mss(mss),
        .m_data(data1), .m_valid(valid1), .m_ready(rdy1), .m_last(last1));

    tcp_header_tx #(.DATA_BYTES(4), .URG_PTR(16'hA55A)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4),
        .ip_sa(sa), .ip_da(da), .payload_len(plen), .payload_sum(psum),
        .src_port(sp), .dst_port(dp), .seq_num(seq), .ack_num(ack),
        .flags(flg), .window(win), .mss(mss),
        .m_data(data4), .m_valid(valid4), .m_ready(rdy4), .m_last(last4));

    task automatic zero_fields();
        m_sa = 0; m_da = 0; m_seq = 0; m_ack = 0; m_plen = 0; m_psum = 0;
        m_sp = 0; m_dp = 0; m_win = 0; m_mss = 0; m_flg = 0;
    endtask

    task automatic rand_fields();
        m_sa = $urandom; m_da = $urandom; m_seq = $urandom; m_ack = $urandom;
        m_plen = 16'($urandom); m_psum = 16'($urandom); m_sp = 16'($urandom);
        m_dp = 16'($urandom); m_win = 16'($urandom); m_mss = 16'($urandom);
        m_flg = 8'($urandom);
    endtask

    task automatic apply_fields();
        sa = m_sa; da = m_da; seq = m_seq; ack = m_ack; plen = m_plen; psum = m_psum;
        sp = m_sp; dp = m_dp; win = m_win; mss = m_mss; flg = m_flg;
    endtask

    // Header as a byte list, checksum = ones' complement of the end-around-carry sum of all 16-bit words.
    task automatic build_exp(input bit w4);
        bit          opt;
        int          hl;
        int unsigned s;
        logic [15:0] urg, tlen, cs;
        opt = 1'b0;
`ifdef TCP_MSS_OPT_EN
        opt = m_flg[1];
`endif
        hl   = opt ? 24 : 20;
        urg  = w4 ? 16'hA55A : 16'h0000;
        tlen = 16'(hl + int'(m_plen));
        exp_q = {m_sp[15:8], m_sp[7:0], m_dp[15:8], m_dp[7:0],
                 m_seq[31:24], m_seq[23:16], m_seq[15:8], m_seq[7:0],
                 m_ack[31:24], m_ack[23:16], m_ack[15:8], m_ack[7:0],
                 8'((hl / 4) << 4), m_flg, m_win[15:8], m_win[7:0],
                 8'h00, 8'h00, urg[15:8], urg[7:0]};
        if (opt) exp_q = {exp_q, 8'h02, 8'h04, m_mss[15:8], m_mss[7:0]};
        s = m_sa[31:16] + m_sa[15:0] + m_da[31:16] + m_da[15:0] + 6 + tlen + m_psum;
        for (int i = 0; i < hl / 2; i++) s += {exp_q[2*i], exp_q[2*i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        exp_q[16] = cs[15:8];
        exp_q[17] = cs[7:0];
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return 1000;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Starts one frame, records handshaked bytes, latency, stall stability; inputs scrambled after accept.
    task automatic run_frame(input bit w4, input int stall_pct, input int hold);
        logic v, l, pl;
        logic [31:0] d, pd;
        bit pstall, done, rdy;
        got_q.delete(); lat = -1; beats = 0; stall_bad = 0;
        done = 0; pstall = 0; pd = 0; pl = 0;
        apply_fields();
        if (w4) start4 = 1'b1; else start1 = 1'b1;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == hold) begin
                start1 = 1'b0; start4 = 1'b0;
                sa = $urandom; seq = $urandom; sp = 16'($urandom); flg = 8'($urandom);
                psum = 16'($urandom); mss = 16'($urandom);
            end
            v = w4 ? valid4 : valid1;
            l = w4 ? last4 : last1;
            d = w4 ? data4 : {24'b0, data1};
            if (v && lat < 0) lat = cyc;
            if (pstall && (!v || d !== pd || l !== pl)) stall_bad++;
            rdy = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            rdy1 = rdy; rdy4 = rdy;
            if (v && rdy) begin
                beats++;
                if (w4) got_q = {got_q, d[31:24], d[23:16], d[15:8], d[7:0]};
                else    got_q = {got_q, d[7:0]};
                if (l) done = 1;
            end
            pstall = v && !rdy; pd = d; pl = l;
        end
        timed_out = !done;
        start1 = 1'b0; start4 = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (busy1 !== 0 || valid1 !== 0 || last1 !== 0 || data1 !== 0) begin
            errors++; $display("FAIL reset_dut1 got busy=%b valid=%b last=%b data=%h want 0 0 0 00", busy1, valid1, last1, data1);
        end
        checks++;
        if (busy4 !== 0 || valid4 !== 0 || last4 !== 0 || data4 !== 0) begin
            errors++; $display("FAIL reset_dut4 got busy=%b valid=%b last=%b data=%h want 0 0 0 0", busy4, valid4, last4, data4);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int d;
        zero_fields(); build_exp(1'b0); run_frame(1'b0, 0, 1);
        checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout got no m_last want m_last"); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency got %0d want 17", lat); end
        checks++; if (beats !== 20) begin errors++; $display("FAIL zero_beats got %0d want 20", beats); end
        checks++;
        if (got_q.size() < 20 || got_q[12] !== 8'h50 || got_q[16] !== 8'hAF || got_q[17] !== 8'hE5) begin
            errors++; $display("FAIL zero_fields got %0d bytes want byte12=50 csum=AF E5", got_q.size());
        end
        d = first_diff();
        checks++; if (d != -1) begin errors++; $display("FAIL zero_stream got diff at byte %0d want none", d); end
        @(posedge clk); #1;
        checks++; if (busy1 !== 0 || valid1 !== 0) begin errors++; $display("FAIL zero_idle got busy=%b valid=%b want 0 0", busy1, valid1); end
    endtask

    task automatic test_carry();
        int d;
        zero_fields(); m_psum = 16'hFFFF; build_exp(1'b0); run_frame(1'b0, 0, 1);
        d = first_diff();
        checks++;
        if (timed_out || d != -1) begin
            errors++; $display("FAIL carry_stream got diff at %0d csum %h%h want %h%h", d,
                               got_q.size() > 17 ? got_q[16] : 8'hxx, got_q.size() > 17 ? got_q[17] : 8'hxx, exp_q[16], exp_q[17]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mss();
        int d;
        zero_fields(); m_flg = 8'h02; m_mss = 16'h05B4; build_exp(1'b0); run_frame(1'b0, 0, 1);
        d = first_diff();
        checks++; if (timed_out || d != -1) begin errors++; $display("FAIL mss_stream got diff at byte %0d want none", d); end
`ifdef TCP_MSS_OPT_EN
        checks++; if (beats !== 24 || lat !== 19) begin errors++; $display("FAIL mss_shape got beats=%0d lat=%0d want 24 19", beats, lat); end
        checks++;
        if (got_q.size() < 24 || got_q[12] !== 8'h60 || got_q[13] !== 8'h02 || got_q[16] !== 8'h98 || got_q[17] !== 8'h27 ||
            got_q[20] !== 8'h02 || got_q[21] !== 8'h04 || got_q[22] !== 8'h05 || got_q[23] !== 8'hB4) begin
            errors++; $display("FAIL mss_bytes got %0d bytes want 60 02 csum 98 27 opt 02 04 05 B4", got_q.size());
        end
`else
        checks++; if (beats !== 20 || lat !== 17) begin errors++; $display("FAIL mss_ignored got beats=%0d lat=%0d want 20 17", beats, lat); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_width4();
        int d;
        zero_fields(); m_sp = 16'h1234; m_dp = 16'h0050; build_exp(1'b1); run_frame(1'b1, 0, 1);
        checks++; if (beats !== 5) begin errors++; $display("FAIL w4_beats got %0d want 5", beats); end
        checks++;
        if (got_q.size() < 4 || {got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'h12340050) begin
            errors++; $display("FAIL w4_beat0 got %0d bytes want 12340050", got_q.size());
        end
        d = first_diff();
        checks++; if (timed_out || d != -1) begin errors++; $display("FAIL w4_stream got diff at byte %0d want none", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int d;
        bit w4;
        for (int k = 0; k < 10; k++) begin
            w4 = k[0];
            rand_fields(); build_exp(w4); run_frame(w4, (k >= 4) ? 50 : 0, 1);
            d = first_diff();
            checks++;
            if (timed_out || d != -1) begin
                errors++; $display("FAIL rand_stream k=%0d got diff at byte %0d want none", k, d);
            end
            checks++;
            if (stall_bad !== 0 || beats !== exp_q.size() / (w4 ? 4 : 1)) begin
                errors++; $display("FAIL rand_flow k=%0d got stall_bad=%0d beats=%0d want 0 %0d", k, stall_bad, beats, exp_q.size() / (w4 ? 4 : 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_double_start();
        int d;
        rand_fields(); build_exp(1'b0); run_frame(1'b0, 0, 2);
        d = first_diff();
        checks++; if (timed_out || d != -1) begin errors++; $display("FAIL dbl_stream got diff at byte %0d want none", d); end
        repeat (2) @(posedge clk); #1;
        checks++; if (busy1 !== 0 || valid1 !== 0) begin errors++; $display("FAIL dbl_ignored got busy=%b valid=%b want 0 0", busy1, valid1); end
    endtask

    task automatic test_reset_mid();
        int n, d;
        bit hit;
        rand_fields(); apply_fields(); start1 = 1'b1; rdy1 = 1'b1; n = 0; hit = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (valid1) begin
                if (n == 7) begin rst = 1'b1; hit = 1; end
                n++;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_reach got %0d beats want 8", n); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (valid1 !== 0 || busy1 !== 0 || last1 !== 0) begin
            errors++; $display("FAIL midrst_state got valid=%b busy=%b last=%b want 0 0 0", valid1, busy1, last1);
        end
        rand_fields(); build_exp(1'b0); run_frame(1'b0, 0, 1);
        d = first_diff();
        checks++; if (timed_out || d != -1 || lat !== (exp_q.size() == 24 ? 19 : 17)) begin
            errors++; $display("FAIL after_rst got diff=%0d lat=%0d want -1 %0d", d, lat, exp_q.size() == 24 ? 19 : 17);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry();
        test_mss();
        test_width4();
        test_random();
        test_double_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
